spi_master_param: RTL and testbench

Parametrised SPI master supporting all four SPI modes, configurable word width, SCK divider and multiple chip selects. Sits between a local controller issuing single-word swaps and external SPI slaves. One full-duplex word per request, MSB first. `data_rx` and `data_good` report completion.

---
 rtl/spi_master_param.sv | 206 ++++++++++++++++++++
 tb/tb_spi_master_param.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// spi_master_param
// ----------------------------------------------------------------------------
// Single-word, full-duplex SPI master, MSB first, all four SPI modes.
// A local controller requests one swap at a time. The block drives SCK, MOSI
// and the selected chip select, shifts in MISO, and then reports the received
// word.
//
// Parameters
//   WIDTH    : bits per transfer (2..32)
//   CLK_DIV  : clk cycles per SCK half-period (H), >= 1
//   CS_COUNT : number of active-low chip selects, >= 1
//
// Ports
//   clk, nRst        : system clock, asynchronous active-low reset
//   start_swap_i     : request, taken only while busy_o is low
//   cpol_i, cpha_i   : SPI mode, captured when a request is accepted
//   cs_sel_i         : slave index; a request with an index >= CS_COUNT is dropped
//   data_tx_i        : word to send, captured when a request is accepted
//   spi_miso_i       : serial data from the slave
//   spi_mosi_o       : serial data to the slave; holds its last bit between words
//   spi_cs_o         : active-low selects; only the captured one is low
//   spi_clk_o        : SCK; idles at the captured cpol
//   data_rx_o        : last received word, held until the next completion
//   data_good_o      : one-cycle pulse when data_rx_o updates
//   busy_o           : high from accept until the next request can be taken
//
// Timeline (cycle 0 = accept): CS low at 1, SCK edge k at 1+k*H,
// CS high + data_good at 1+(2W+1)*H, busy low at 1+(2W+2)*H.
module spi_master_param #(
    parameter  int WIDTH    = 8,
    parameter  int CLK_DIV  = 2,
    parameter  int CS_COUNT = 1,
    localparam int CSW      = (CS_COUNT > 2) ? $clog2(CS_COUNT) : 1
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                start_swap_i,
    input  logic                cpol_i,
    input  logic                cpha_i,
    input  logic [CSW-1:0]      cs_sel_i,
    input  logic [WIDTH-1:0]    data_tx_i,
    input  logic                spi_miso_i,
    output logic                spi_mosi_o,
    output logic [CS_COUNT-1:0] spi_cs_o,
    output logic                spi_clk_o,
    output logic [WIDTH-1:0]    data_rx_o,
    output logic                data_good_o,
    output logic                busy_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EW = $clog2(2 * WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [EW-1:0]  LAST_EDGE = EW'(2 * WIDTH);
    localparam logic [CSW:0]   CS_LIM    = CS_COUNT[CSW:0];

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [EW-1:0]       edge_q, edge_d;
    logic [WIDTH-1:0]    tx_q, tx_d;
    logic [WIDTH-1:0]    rx_q, rx_d;
    logic [WIDTH-1:0]    data_rx_q, data_rx_d;
    logic [CS_COUNT-1:0] cs_q, cs_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic                good_q, good_d;
    logic                busy_q, busy_d;

    logic                cnt_done;
    logic [EW-1:0]       edge_n;
    logic                cs_ok;

    assign cnt_done = (cnt_q == CNT_LAST);
    assign edge_n   = edge_q + 1'b1;
    assign cs_ok    = ({1'b0, cs_sel_i} < CS_LIM);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            edge_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            data_rx_q <= '0;
            cs_q      <= '1;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            good_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            data_rx_q <= data_rx_d;
            cs_q      <= cs_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            good_q    <= good_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        data_rx_d = data_rx_q;
        cs_d      = cs_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        good_d    = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                sck_d = cpol_q;
                if (start_swap_i && cs_ok) begin
                    cpol_d = cpol_i;
                    cpha_d = cpha_i;
                    sck_d  = cpol_i;
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    edge_d = '0;
                    rx_d   = '0;
                    for (int i = 0; i < CS_COUNT; i++)
                        cs_d[i] = (cs_sel_i != CSW'(i));
                    // cpha=0 puts the MSB out before the first edge; cpha=1
                    // drives it on edge 1, so keep the whole word queued.
                    if (!cpha_i) begin
                        mosi_d = data_tx_i[WIDTH-1];
                        tx_d   = {data_tx_i[WIDTH-2:0], 1'b0};
                    end else begin
                        tx_d   = data_tx_i;
                    end
                    state_d = LEAD;
                end
            end

            // LEAD ends with edge 1, so it shares the edge logic with SHIFT.
            LEAD, SHIFT: begin
                if (cnt_done) begin
                    cnt_d  = '0;
                    sck_d  = ~sck_q;
                    edge_d = edge_n;
                    // Sample on odd edges for cpha=0, even edges for cpha=1;
                    // the other edges drive, except the final edge.
                    if (edge_n[0] != cpha_q) begin
                        rx_d = {rx_q[WIDTH-2:0], spi_miso_i};
                    end else if (edge_n != LAST_EDGE) begin
                        mosi_d = tx_q[WIDTH-1];
                        tx_d   = {tx_q[WIDTH-2:0], 1'b0};
                    end
                    state_d = (edge_n == LAST_EDGE) ? TRAIL : SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            TRAIL: begin
                if (cnt_done) begin
                    cnt_d     = '0;
                    cs_d      = '1;
                    data_rx_d = rx_q;
                    good_d    = 1'b1;
                    state_d   = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            GAP: begin
                if (cnt_done) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign spi_mosi_o  = mosi_q;
    assign spi_cs_o    = cs_q;
    assign spi_clk_o   = sck_q;
    assign data_rx_o   = data_rx_q;
    assign data_good_o = good_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_spi_master_param.sv
module tb_spi_master_param;

    logic clk  = 1'b0;
    logic nRst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] rx;
        logic [7:0]  slv;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- u0: WIDTH=8, CLK_DIV=2, CS_COUNT=5 ----------------
    logic       st0 = 1'b0, cpol0 = 1'b0, cpha0 = 1'b0, loop0 = 1'b1;
    logic [2:0] sel0 = '0;
    logic [7:0] tx0 = '0;
    logic [7:0] rx0;
    logic [4:0] cs0;
    logic       mosi0, sck0, dg0, busy0, miso0;

    // Mode-aware slave returning 0x3C; sampled on negedge, away from DUT updates.
    logic       sl_act = 1'b0, sl_prev = 1'b0, sl_miso = 1'b0;
    int         sl_edges = 0;
    logic [7:0] sl_tx = '0, sl_rx = '0;

    always @(negedge clk) begin
        if (&cs0) begin
            sl_act = 1'b0;
        end else if (!sl_act) begin
            sl_act   = 1'b1;
            sl_edges = 0;
            sl_rx    = '0;
            sl_tx    = 8'h3C;
            sl_prev  = sck0;
            if (!cpha0) begin
                sl_miso = sl_tx[7];
                sl_tx   = {sl_tx[6:0], 1'b0};
            end
        end else if (sck0 != sl_prev) begin
            sl_prev = sck0;
            sl_edges++;
            if ((sl_edges % 2 == 1) == (cpha0 == 1'b0)) begin
                sl_rx = {sl_rx[6:0], mosi0};
            end else begin
                sl_miso = sl_tx[7];
                sl_tx   = {sl_tx[6:0], 1'b0};
            end
        end
    end

    assign miso0 = loop0 ? mosi0 : sl_miso;

    spi_master_param #(.WIDTH(8), .CLK_DIV(2), .CS_COUNT(5)) u0 (
        .clk(clk), .nRst(nRst), .start_swap_i(st0), .cpol_i(cpol0), .cpha_i(cpha0),
        .cs_sel_i(sel0), .data_tx_i(tx0), .spi_miso_i(miso0), .spi_mosi_o(mosi0),
        .spi_cs_o(cs0), .spi_clk_o(sck0), .data_rx_o(rx0), .data_good_o(dg0), .busy_o(busy0)
    );

    // ---------------- u1: WIDTH=16, CLK_DIV=1, CS_COUNT=1, loopback ----------------
    logic        st1 = 1'b0;
    logic [0:0]  sel1 = '0;
    logic [15:0] tx1 = '0;
    logic [15:0] rx1;
    logic [0:0]  cs1;
    logic        mosi1, sck1, dg1, busy1;

    spi_master_param #(.WIDTH(16), .CLK_DIV(1), .CS_COUNT(1)) u1 (
        .clk(clk), .nRst(nRst), .start_swap_i(st1), .cpol_i(1'b0), .cpha_i(1'b0),
        .cs_sel_i(sel1), .data_tx_i(tx1), .spi_miso_i(mosi1), .spi_mosi_o(mosi1),
        .spi_cs_o(cs1), .spi_clk_o(sck1), .data_rx_o(rx1), .data_good_o(dg1), .busy_o(busy1)
    );

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        exp_t e;
        if (nRst && dg0) begin
            if (q0.size() == 0) begin
                tests++; fails++;
                $display("FAIL u0_unexpected_good: got data_good with rx=0x%0h, expected none", rx0);
            end else begin
                e = q0.pop_front();
                chk("u0_rx", 32'(rx0), e.rx);
                chk("u0_good_cycle", cyc, e.cyc);
                chk("u0_slave_rx", 32'(sl_rx), 32'(e.slv));
                chk("u0_sck_edges", sl_edges, 16);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (nRst && dg1) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL u1_unexpected_good: got data_good with rx=0x%0h, expected none", rx1);
            end else begin
                e = q1.pop_front();
                chk("u1_rx", 32'(rx1), e.rx);
                chk("u1_good_cycle", cyc, e.cyc);
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic issue0(input logic [7:0] d, input logic pol, input logic pha,
                          input logic [2:0] sel, input bit push,
                          input logic [7:0] exp_rx, input logic [7:0] exp_slv, output int t0);
        tx0 = d; cpol0 = pol; cpha0 = pha; sel0 = sel; st0 = 1'b1;
        t0 = cyc;
        if (push) q0.push_back('{rx: 32'(exp_rx), slv: exp_slv, cyc: t0 + 35});
        @(negedge clk);
        st0 = 1'b0;
    endtask

    task automatic idle0(output int tf);
        int n = 0;
        while (busy0 && n < 300) begin @(negedge clk); n++; end
        tf = cyc;
        if (busy0) begin
            tests++; fails++;
            $display("FAIL u0_idle_timeout: busy=1 after %0d cycles, expected 0", n);
        end
    endtask

    task automatic issue1(input logic [15:0] d, output int t0);
        tx1 = d; st1 = 1'b1;
        t0 = cyc;
        q1.push_back('{rx: 32'(d), slv: 8'h00, cyc: t0 + 34});
        @(negedge clk);
        st1 = 1'b0;
    endtask

    task automatic idle1(output int tf);
        int n = 0;
        while (busy1 && n < 300) begin @(negedge clk); n++; end
        tf = cyc;
        if (busy1) begin
            tests++; fails++;
            $display("FAIL u1_idle_timeout: busy=1 after %0d cycles, expected 0", n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, tf;

        repeat (3) @(negedge clk);
        chk("rst_cs", 32'(cs0), 32'h1F);
        chk("rst_sck", 32'(sck0), 0);
        chk("rst_mosi", 32'(mosi0), 0);
        chk("rst_rx", 32'(rx0), 0);
        chk("rst_good", 32'(dg0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_u1_cs", 32'(cs1), 1);
        nRst = 1'b1;
        @(negedge clk);

        // Abort: mode 2 transfer, reset just before edge 7 while SCK is high.
        loop0 = 1'b1;
        issue0(8'h77, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, t0);
        chk("abort_busy_rise", 32'(busy0), 1);
        chk("abort_cs_low", 32'(cs0), 32'h1E);
        while (cyc < t0 + 14) @(negedge clk);
        chk("abort_sck_before", 32'(sck0), 1);
        nRst = 1'b0;
        #1;
        chk("abort_cs", 32'(cs0), 32'h1F);
        chk("abort_sck", 32'(sck0), 0);
        chk("abort_busy", 32'(busy0), 0);
        chk("abort_rx", 32'(rx0), 0);
        chk("abort_good", 32'(dg0), 0);
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);

        // Loopback, mode 0.
        issue0(8'hA5, 1'b0, 1'b0, 3'd0, 1'b1, 8'hA5, 8'hA5, t0);
        idle0(tf);
        chk("lb_busy_fall", tf, t0 + 37);
        chk("lb_sck_idle", 32'(sck0), 0);

        // Slave model, all four modes.
        loop0 = 1'b0;
        for (int m = 0; m < 4; m++) begin
            issue0(8'hC3, m[1], m[0], 3'd0, 1'b1, 8'h3C, 8'hC3, t0);
            idle0(tf);
            chk("mode_busy_fall", tf, t0 + 37);
            chk("mode_sck_idle", 32'(sck0), 32'(m[1]));
        end

        // Chip select 2 only.
        loop0 = 1'b1;
        issue0(8'h96, 1'b0, 1'b0, 3'd2, 1'b1, 8'h96, 8'h96, t0);
        chk("cs2_first", 32'(cs0), 32'h1B);
        while (cyc < t0 + 34) @(negedge clk);
        chk("cs2_last", 32'(cs0), 32'h1B);
        @(negedge clk);
        chk("cs2_release", 32'(cs0), 32'h1F);
        idle0(tf);

        // Request during a transfer is dropped.
        issue0(8'h5A, 1'b0, 1'b0, 3'd0, 1'b1, 8'h5A, 8'h5A, t0);
        while (cyc < t0 + 10) @(negedge clk);
        tx0 = 8'hFF; sel0 = 3'd1; st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        idle0(tf);
        chk("ign_busy_fall", tf, t0 + 37);

        // Back-to-back: issued in the busy-fall cycle.
        issue0(8'h0F, 1'b0, 1'b0, 3'd0, 1'b1, 8'h0F, 8'h0F, t0);
        chk("b2b_cs_low", 32'(cs0), 32'h1E);
        chk("b2b_busy", 32'(busy0), 1);
        idle0(tf);

        // Out-of-range select is ignored.
        sel0 = 3'd5; st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        chk("sel5_busy", 32'(busy0), 0);
        chk("sel5_cs", 32'(cs0), 32'h1F);
        repeat (4) @(negedge clk);
        chk("sel5_busy_later", 32'(busy0), 0);

        // WIDTH=16, CLK_DIV=1 loopback.
        issue1(16'h8001, t0);
        idle1(tf);
        chk("w16_busy_fall", tf, t0 + 35);
        issue1(16'h4B2D, t0);
        idle1(tf);
        chk("w16_busy_fall2", tf, t0 + 35);

        repeat (5) @(negedge clk);
        chk("u0_queue_drained", q0.size(), 0);
        chk("u1_queue_drained", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
